// File: rtl/vga_scan_controller_pkg.sv
// Shared VGA raster definitions: default 640x480 timing, image window placement and scan FSM states.
package vga_scan_controller_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_VISIBLE_D = 640;
  localparam int unsigned H_FRONT_D   = 16;
  localparam int unsigned H_SYNC_D    = 96;
  localparam int unsigned H_BACK_D    = 48;
  localparam int unsigned H_TOTAL_D   = H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
  localparam int unsigned H_SYNC_START_D = H_VISIBLE_D + H_FRONT_D;
  localparam int unsigned H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D;

  localparam int unsigned V_VISIBLE_D = 480;
  localparam int unsigned V_FRONT_D   = 10;
  localparam int unsigned V_SYNC_D    = 2;
  localparam int unsigned V_BACK_D    = 33;
  localparam int unsigned V_TOTAL_D   = V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;
  localparam int unsigned V_SYNC_START_D = V_VISIBLE_D + V_FRONT_D;
  localparam int unsigned V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D;

  localparam int unsigned IMG_W_D  = 390;
  localparam int unsigned IMG_H_D  = 80;
  localparam int unsigned IMG_X0_D = 125;
  localparam int unsigned IMG_Y0_D = 200;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN
  } scan_state_t;

  // Half-open interval test [lo, hi) on a counter value.
  function automatic logic in_range(input logic [CNT_W-1:0] x,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo counter for one raster axis; wrap pulses on the advancing step that returns to zero.
module vga_axis_counter
  import vga_scan_controller_pkg::*;
#(
  parameter int unsigned MODULUS = H_TOTAL_D,
  parameter int unsigned WIDTH   = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster walker: counters -> window/sync decode (stage 1) -> registered colour and sync pins (stage 2).
module vga_scan_controller
  import vga_scan_controller_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_D,
  parameter int unsigned H_FRONT   = H_FRONT_D,
  parameter int unsigned H_SYNC    = H_SYNC_D,
  parameter int unsigned H_BACK    = H_BACK_D,
  parameter int unsigned V_VISIBLE = V_VISIBLE_D,
  parameter int unsigned V_FRONT   = V_FRONT_D,
  parameter int unsigned V_SYNC    = V_SYNC_D,
  parameter int unsigned V_BACK    = V_BACK_D,
  parameter int unsigned IMG_W     = IMG_W_D,
  parameter int unsigned IMG_H     = IMG_H_D,
  parameter int unsigned IMG_X0    = IMG_X0_D,
  parameter int unsigned IMG_Y0    = IMG_Y0_D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic        run,
  output logic [15:0] row,
  output logic [15:0] column,
  output logic        enable,
  input  logic        r_in,
  input  logic        g_in,
  input  logic        b_in,
  output logic        red,
  output logic        green,
  output logic        blue,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] IMG_X_LO = CNT_W'(IMG_X0);
  localparam logic [CNT_W-1:0] IMG_X_HI = CNT_W'(IMG_X0 + IMG_W);
  localparam logic [CNT_W-1:0] IMG_Y_LO = CNT_W'(IMG_Y0);
  localparam logic [CNT_W-1:0] IMG_Y_HI = CNT_W'(IMG_Y0 + IMG_H);

  scan_state_t      state;
  logic             scanning;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, frame_end;
  logic             in_img;
  logic [CNT_W-1:0] row_c, col_c;
  logic             hsync_s1, vsync_s1, active_s1, frame_s1;

  assign scanning = (state != IDLE);

  vga_axis_counter #(.MODULUS(H_TOTAL), .WIDTH(CNT_W)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (pix_ce && scanning),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  // frame_end marks the last pixel of the frame (h and v both wrapping on this step).
  vga_axis_counter #(.MODULUS(V_TOTAL), .WIDTH(CNT_W)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap),
    .count (v_cnt),
    .wrap  (frame_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (pix_ce) begin
      case (state)
        IDLE:    if (run) state <= RUN;
        RUN:     if (!run) state <= DRAIN;
        DRAIN: begin
          if (run) state <= RUN;
          else if (frame_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_img = in_range(h_cnt, IMG_X_LO, IMG_X_HI) && in_range(v_cnt, IMG_Y_LO, IMG_Y_HI);
  assign row_c  = v_cnt - IMG_Y_LO;
  assign col_c  = h_cnt - IMG_X_LO;

  always_ff @(posedge clk) begin
    if (reset || (pix_ce && !scanning)) begin
      enable    <= 1'b0;
      row       <= '0;
      column    <= '0;
      hsync_s1  <= 1'b1;
      vsync_s1  <= 1'b1;
      active_s1 <= 1'b0;
      frame_s1  <= 1'b0;
    end else if (pix_ce) begin
      enable    <= in_img;
      row       <= in_img ? {{(16-CNT_W){1'b0}}, row_c} : '0;
      column    <= in_img ? {{(16-CNT_W){1'b0}}, col_c} : '0;
      hsync_s1  <= !in_range(h_cnt, HS_LO, HS_HI);
      vsync_s1  <= !in_range(v_cnt, VS_LO, VS_HI);
      active_s1 <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
      frame_s1  <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // The source answers the stage-1 row/column combinationally, so colour lands with its own sync.
  always_ff @(posedge clk) begin
    if (reset || (pix_ce && !scanning)) begin
      red         <= 1'b0;
      green       <= 1'b0;
      blue        <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      red         <= enable && r_in;
      green       <= enable && g_in;
      blue        <= enable && b_in;
      hsync       <= hsync_s1;
      vsync       <= vsync_s1;
      active      <= active_s1;
      frame_start <= frame_s1;
    end
  end

endmodule
